// File: rtl/countdown_scheduler.sv
// countdown_scheduler: round-robin arbiter sharing one countdown timer among NUM_REQ requesters.
// A grant loads the owner's duration, counts it to zero, then pulses that owner's done.
module countdown_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 5
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*WIDTH-1:0] i_dur,
    output logic [NUM_REQ-1:0]       o_gnt,
    output logic [NUM_REQ-1:0]       o_done,
    output logic [WIDTH-1:0]         o_count,
    output logic                     o_busy
);
    localparam int LW = $clog2(NUM_REQ);
    localparam int IW = LW + 1;
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t r_state, w_state_nxt;
    logic [LW-1:0] r_last, r_id, w_win, w_last_nxt, w_id_nxt;
    logic [IW-1:0] w_idx;
    logic w_any;
    logic [NUM_REQ-1:0] r_gnt, r_done, w_gnt_nxt, w_done_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic r_busy;
    // Scan from the slot after the last served requester, wrapping, so every active requester gets a turn.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = IW'(r_last) + IW'(k) + IW'(1);
            if (w_idx >= IW'(NUM_REQ)) w_idx = w_idx - IW'(NUM_REQ);
            if (!w_any && i_req[w_idx[LW-1:0]]) begin
                w_any = 1'b1;
                w_win = w_idx[LW-1:0];
            end
        end
    end
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_count_nxt = r_count;
        w_last_nxt  = r_last;
        w_id_nxt    = r_id;
        case (r_state)
            S_IDLE: if (w_any) begin
                w_state_nxt = S_RUN;
                w_id_nxt    = w_win;
                w_gnt_nxt   = ONE << w_win;
                w_count_nxt = i_dur[w_win*WIDTH +: WIDTH];
            end
            // Abort wins over reaching zero; both end the turn and advance the rotation.
            S_RUN: if (!i_req[r_id]) begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_count_nxt = '0;
                w_last_nxt  = r_id;
            end else if (r_count == '0) begin
                w_state_nxt = S_DONE;
                w_gnt_nxt   = '0;
                w_done_nxt  = ONE << r_id;
                w_last_nxt  = r_id;
            end else begin
                w_count_nxt = r_count - 1'b1;
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_count_nxt = '0;
            end
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_last  <= LW'(NUM_REQ - 1);
            r_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_count <= w_count_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_last  <= w_last_nxt;
            r_id    <= w_id_nxt;
        end
    end
    assign o_gnt   = r_gnt;
    assign o_done  = r_done;
    assign o_count = r_count;
    assign o_busy  = r_busy;
endmodule

// File: tb/tb_countdown_scheduler.sv
// tb_countdown_scheduler: directed scenarios plus random traffic checked cycle by cycle
// against a job-level reference model (grant, elapsed-cycle count, rotation pointer).
module tb_countdown_scheduler;
    localparam int N = 4;
    localparam int W = 5;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] dur = '0;
    logic [N-1:0] o_gnt, o_done;
    logic [W-1:0] o_count;
    logic o_busy;
    int n_vec = 0;
    int n_err = 0;
    int m_ph = 0, m_own = 0, m_last = N - 1, m_t = 0, m_dur = 0;

    countdown_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_req(req), .i_dur(dur),
        .o_gnt(o_gnt), .o_done(o_done), .o_count(o_count), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Phase 0 idle, 1 running (m_t cycles elapsed since grant), 2 done pulse.
    function automatic void model_edge();
        bit found;
        int c;
        if (!rst_n) begin
            m_ph = 0; m_last = N - 1; m_t = 0; m_dur = 0; m_own = 0;
        end else if (m_ph == 0) begin
            found = 0;
            for (int i = 1; i <= N; i++) begin
                c = (m_last + i) % N;
                if (!found && req[c]) begin
                    found = 1;
                    m_own = c;
                end
            end
            if (found) begin
                m_dur = int'(dur[m_own*W +: W]);
                m_t = 0;
                m_ph = 1;
            end
        end else if (m_ph == 1) begin
            if (!req[m_own]) begin
                m_ph = 0; m_last = m_own;
            end else if (m_t == m_dur) begin
                m_ph = 2; m_last = m_own;
            end else begin
                m_t++;
            end
        end else begin
            m_ph = 0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("gnt", 32'(o_gnt), (m_ph == 1) ? (32'd1 << m_own) : 32'd0);
        chk("done", 32'(o_done), (m_ph == 2) ? (32'd1 << m_own) : 32'd0);
        chk("count", 32'(o_count), (m_ph == 1) ? 32'(m_dur - m_t) : 32'd0);
        chk("busy", 32'(o_busy), 32'(m_ph != 0));
        chk("gnt_done_excl", 32'(|(o_gnt & o_done)), 32'd0);
        chk("onehot", 32'($countones(o_gnt) <= 1 && $countones(o_done) <= 1), 32'd1);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_run(input logic [N-1:0] g, input int c, input string tag);
        bit found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (o_gnt == g && int'(o_count) == c) found = 1;
            else step();
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        steps(2);
        chk("rst_count", 32'(o_count), 32'd0);
        rst_n = 1'b1;
        // single request, dur 3
        dur[0*W +: W] = 5'd3;
        req = 4'b0001;
        steps(6);
        req = '0;
        steps(2);
        // round robin, all dur 2
        for (int i = 0; i < N; i++) dur[i*W +: W] = 5'd2;
        req = 4'b1111;
        steps(27);
        req = '0;
        steps(3);
        // zero and max duration
        dur[0*W +: W] = 5'd0;
        req = 4'b0001;
        steps(4);
        req = '0;
        steps(2);
        dur[0*W +: W] = 5'd31;
        req = 4'b0001;
        steps(36);
        req = '0;
        steps(2);
        // abort of requester 1 at count 4, requester 2 pending
        dur[1*W +: W] = 5'd8;
        dur[2*W +: W] = 5'd3;
        req = 4'b0110;
        wait_run(4'b0010, 4, "wait_abort");
        req = 4'b0100;
        step();
        chk("abort_gnt", 32'(o_gnt), 32'd0);
        step();
        chk("after_abort_gnt", 32'(o_gnt), 32'h4);
        steps(6);
        req = '0;
        steps(2);
        // mid-run reset at count 10
        dur[0*W +: W] = 5'd20;
        req = 4'b0001;
        wait_run(4'b0001, 10, "wait_rst");
        rst_n = 1'b0;
        step();
        chk("rst_busy", 32'(o_busy), 32'd0);
        rst_n = 1'b1;
        req = 4'b1010;
        step();
        chk("rst_first_gnt", 32'(o_gnt), 32'h2);
        req = '0;
        steps(3);
        // late dur change during RUN
        dur[0*W +: W] = 5'd5;
        req = 4'b0001;
        step();
        dur[0*W +: W] = 5'd20;
        steps(5);
        chk("late_count0", 32'(o_count), 32'd0);
        step();
        chk("late_done", 32'(o_done), 32'h1);
        req = '0;
        steps(2);
        // random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) req = N'($urandom);
            dur = (N*W)'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
